// File: rtl/issue_ctrl_pkg.sv
// Shared types and constants for the instruction issue controller.
package issue_ctrl_pkg;

   localparam int unsigned INSTR_W  = 32;
   localparam int unsigned OPC_W    = 6;
   localparam int unsigned REG_W    = 5;
   localparam int unsigned OPC_LSB  = 26;
   localparam int unsigned SRC1_LSB = 21;
   localparam int unsigned SRC2_LSB = 16;
   localparam int unsigned RDST_LSB = 11;
   localparam int unsigned DEC_W    = INSTR_W - RDST_LSB;

   localparam logic [OPC_W-1:0] OPC_RFORMAT = 6'h00;
   localparam logic [OPC_W-1:0] OPC_ADDI    = 6'h03;
   localparam logic [OPC_W-1:0] OPC_SUBI    = 6'h0B;
   localparam logic [OPC_W-1:0] OPC_ANDI    = 6'h0C;
   localparam logic [OPC_W-1:0] OPC_ORI     = 6'h0D;
   localparam logic [OPC_W-1:0] OPC_XORI    = 6'h0E;

   // OR R0,R0,R0
   localparam logic [INSTR_W-1:0] BUBBLE_INSTR = 32'h0000_0004;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2
   } state_e;

   typedef struct packed {
      logic [REG_W-1:0] src1;
      logic [REG_W-1:0] src2;
      logic             has_src2;
      logic [REG_W-1:0] dest;
   } dec_t;

   // Takes instr[31:11]; the low bits never name a register.
   function automatic dec_t decode(input logic [DEC_W-1:0] f);
      dec_t d;
      logic is_r;
      is_r       = (f[OPC_LSB-RDST_LSB +: OPC_W] == OPC_RFORMAT);
      d.src1     = f[SRC1_LSB-RDST_LSB +: REG_W];
      d.src2     = f[SRC2_LSB-RDST_LSB +: REG_W];
      d.has_src2 = is_r;
      d.dest     = is_r ? f[0 +: REG_W] : f[SRC2_LSB-RDST_LSB +: REG_W];
      return d;
   endfunction

endpackage

// File: rtl/issue_fifo.sv
// Instruction queue: storage, wrapping pointers and a separate occupancy count.
module issue_fifo #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_i,
   input  logic              flush_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] head_o,
   output logic              empty_o,
   output logic              ready_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign ready_o = (count_q < CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rptr_q];

   // A full queue refuses a push even if the head leaves this cycle.
   always_comb begin
      do_push = push_i && ready_o && !flush_i && !reset_i;
      do_pop  = pop_i && !empty_o && !flush_i && !reset_i;
      wptr_d  = do_push ? ptr_inc(wptr_q) : wptr_q;
      rptr_d  = do_pop  ? ptr_inc(rptr_q) : rptr_q;
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      if (flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/issue_ctrl.sv
// Queues CPU instructions and issues them on ibus, inserting bubbles on RAW hazards.
// Define ISSUE_BYPASS_EN to check only the last issued destination (EX forwarding).
module issue_ctrl
   import issue_ctrl_pkg::*;
#(
   parameter int unsigned         FIFO_DEPTH = 4,
   parameter int unsigned         HAZ_WIN    = 2,
   parameter logic [INSTR_W-1:0]  BUBBLE     = BUBBLE_INSTR
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic [INSTR_W-1:0] in_instr,
   output logic               in_ready,
   input  logic               flush,
   output logic [INSTR_W-1:0] ibus_out,
   output logic               stall,
   output logic [15:0]        bubble_cnt
);

`ifdef ISSUE_BYPASS_EN
   localparam int unsigned WIN = 1;
`else
   localparam int unsigned WIN = HAZ_WIN;
`endif

   logic [INSTR_W-1:0] head;
   logic               empty;
   logic               head_valid;
   dec_t               head_dec;
   logic               hazard_c;
   logic               pop_c;

   state_e             state_q;
   logic [INSTR_W-1:0] ibus_q;
   logic [15:0]        bub_q;
   logic [REG_W-1:0]   hist_q [HAZ_WIN];

   issue_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (INSTR_W)
   ) u_fifo (
      .clk     (clk),
      .reset_i (reset),
      .flush_i (flush),
      .push_i  (in_valid),
      .pop_i   (pop_c),
      .data_i  (in_instr),
      .head_o  (head),
      .empty_o (empty),
      .ready_o (in_ready)
   );

   assign head_valid = !empty;

   // RAW check of the head against the recent destinations; R0 never blocks.
   always_comb begin
      head_dec = decode(head[INSTR_W-1:RDST_LSB]);
      hazard_c = 1'b0;
      for (int i = 0; i < int'(WIN); i++) begin
         if (hist_q[i] != '0 &&
             (hist_q[i] == head_dec.src1 ||
              (head_dec.has_src2 && hist_q[i] == head_dec.src2))) begin
            hazard_c = 1'b1;
         end
      end
      hazard_c = hazard_c && head_valid;
      pop_c    = head_valid && !hazard_c;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ibus_q  <= BUBBLE;
         bub_q   <= '0;
         for (int i = 0; i < int'(HAZ_WIN); i++) hist_q[i] <= '0;
      end else if (flush) begin
         state_q <= ST_IDLE;
         ibus_q  <= BUBBLE;
         for (int i = 0; i < int'(HAZ_WIN); i++) hist_q[i] <= '0;
      end else begin
         for (int i = 1; i < int'(HAZ_WIN); i++) hist_q[i] <= hist_q[i-1];
         if (pop_c) begin
            state_q   <= ST_RUN;
            ibus_q    <= head;
            hist_q[0] <= head_dec.dest;
         end else begin
            ibus_q    <= BUBBLE;
            hist_q[0] <= '0;
            if (head_valid) begin
               state_q <= ST_STALL;
               if (bub_q != 16'hFFFF) bub_q <= bub_q + 16'd1;
            end else begin
               state_q <= ST_IDLE;
            end
         end
      end
   end

   assign ibus_out   = ibus_q;
   assign stall      = (state_q == ST_STALL);
   assign bubble_cnt = bub_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Scoreboard bench for issue_ctrl: issue order checked by a monitor, timing by directed checks.
module tb_issue_ctrl;

   localparam logic [31:0] BUB  = 32'h0000_0004;
   localparam logic [31:0] I_A  = 32'h3001_FFFF;   // dest R1
   localparam logic [31:0] I_B  = 32'h0C02_00FF;   // ADDI R2,R0
   localparam logic [31:0] I_C  = 32'h0C22_0001;   // ADDI R2,R1
   localparam logic [31:0] I_D  = 32'h0C03_00AA;   // ADDI R3,R0
`ifdef ISSUE_BYPASS_EN
   localparam int NB = 1;
`else
   localparam int NB = 2;
`endif

   logic        clk = 1'b0;
   logic        reset, in_valid, flush;
   logic [31:0] in_instr;
   logic        in_ready, stall;
   logic [31:0] ibus_out;
   logic [15:0] bubble_cnt;

   int          tests = 0;
   int          fails = 0;
   int          stall_cnt = 0;
   int          exp_bub = 0;
   int          s0;
   bit          full_seen = 1'b0;
   logic [31:0] sb [$];

   issue_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_instr   (in_instr),
      .in_ready   (in_ready),
      .flush      (flush),
      .ibus_out   (ibus_out),
      .stall      (stall),
      .bubble_cnt (bubble_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every real instruction on ibus must be the oldest expected one.
   always @(negedge clk) begin
      if (stall === 1'b1) stall_cnt++;
      if (in_ready === 1'b0) full_seen = 1'b1;
      if (ibus_out !== BUB) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL issue_unexpected: got %h expected none", ibus_out);
         end else begin
            check("issue_order", ibus_out, sb.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic push(input logic [31:0] w);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_instr = w;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (n == 50) begin
         tests++;
         fails++;
         $display("FAIL push_timeout: got in_ready=0 expected 1 for %h", w);
      end else begin
         sb.push_back(w);
         tick();
      end
      in_valid = 1'b0;
   endtask

   function automatic logic [31:0] chain_w(input int k);
      return 32'h0C00_0000 | (32'(k) << 21) | (32'(k + 1) << 16);
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
      idle(2);
      check("rst_ibus", ibus_out, BUB);
      check("rst_stall", 32'(stall), 0);
      check("rst_bcnt", 32'(bubble_cnt), 0);
      check("rst_ready", 32'(in_ready), 1);
      reset = 1'b0;
      tick();

      // Independent stream issues back to back
      s0 = stall_cnt;
      push(I_A);
      check("ind_no_bypass", ibus_out, BUB);
      push(I_B);
      check("ind_first", ibus_out, I_A);
      tick();
      check("ind_second", ibus_out, I_B);
      idle(3);
      check("ind_stalls", 32'(stall_cnt - s0), 0);
      check("ind_bcnt", 32'(bubble_cnt), 0);

      // RAW hazard on R1
      push(I_A);
      push(I_C);
      check("raw_prod", ibus_out, I_A);
      for (int i = 0; i < NB; i++) begin
         tick();
         check("raw_bubble", ibus_out, BUB);
         check("raw_stall", 32'(stall), 1);
      end
      tick();
      check("raw_cons", ibus_out, I_C);
      check("raw_stall_end", 32'(stall), 0);
      exp_bub += NB;
      check("raw_bcnt", 32'(bubble_cnt), 32'(exp_bub));

      // R0 never creates a hazard
      idle(3);
      s0 = stall_cnt;
      push(32'h0000_0801);
      push(32'h0C03_0001);
      check("r0_a", ibus_out, 32'h0000_0801);
      tick();
      check("r0_b", ibus_out, 32'h0C03_0001);
      idle(3);
      push(32'h0C20_0005);
      push(32'h0000_1000);
      check("r0_c", ibus_out, 32'h0C20_0005);
      tick();
      check("r0_d", ibus_out, 32'h0000_1000);
      check("r0_stalls", 32'(stall_cnt - s0), 0);
      check("r0_bcnt", 32'(bubble_cnt), 32'(exp_bub));

      // Dependency chain fills the queue
      idle(3);
      full_seen = 1'b0;
      for (int k = 0; k < 8; k++) push(chain_w(k));
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      check("full_drained", 32'(sb.size()), 0);
      check("full_seen", 32'(full_seen), 1);
      exp_bub += 7 * NB;
      check("full_bcnt", 32'(bubble_cnt), 32'(exp_bub));

      // Flush mid-stall
      idle(3);
      push(I_A);
      push(I_C);
      push(I_D);
      check("fl_bubble", ibus_out, BUB);
      check("fl_stall", 32'(stall), 1);
      exp_bub += 1;
      flush = 1'b1;
      sb.delete();
      tick();
      flush = 1'b0;
      check("fl_ibus", ibus_out, BUB);
      check("fl_stall_clr", 32'(stall), 0);
      check("fl_ready", 32'(in_ready), 1);
      check("fl_bcnt_kept", 32'(bubble_cnt), 32'(exp_bub));
      push(I_C);
      tick();
      check("fl_empty_next", ibus_out, I_C);

      // Reset mid-stall overrides flush and push
      idle(3);
      push(I_A);
      push(I_C);
      tick();
      check("rs_stall", 32'(stall), 1);
      reset = 1'b1; flush = 1'b1; in_valid = 1'b1; in_instr = I_D;
      sb.delete();
      tick();
      check("rs_ibus", ibus_out, BUB);
      check("rs_stall_clr", 32'(stall), 0);
      check("rs_bcnt", 32'(bubble_cnt), 0);
      check("rs_ready", 32'(in_ready), 1);
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
      idle(4);
      push(I_B);
      tick();
      check("rs_empty_next", ibus_out, I_B);
      idle(3);
      check("end_sb_empty", 32'(sb.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
